// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter: shares one memory port between instruction fetch and data
// access. Data wins over fetch, except that a pending fetch is forced through
// after FAIRNESS consecutive data grants. Each access is strobed until
// mem_ready or a TIMEOUT-cycle limit, then reported with a one-cycle valid.
module scc_mem_arbiter #(
   parameter int unsigned FAIRNESS = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_mem_en,
   input  logic [31:0] in_mem_addr,
   output logic [31:0] in_mem,
   output logic        in_mem_valid,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_out,
   output logic [31:0] data_in,
   output logic        data_valid,
   output logic        bus_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_e;

   localparam logic [3:0] FAIR_MAX = 4'(FAIRNESS);
   // Last wait count before the strobe is abandoned: strobe lasts TIMEOUT cycles.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [3:0]  fair_q, fair_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;
   logic [31:0] in_mem_q, in_mem_d;
   logic [31:0] data_in_q, data_in_d;
   logic        in_vld_q, in_vld_d;
   logic        d_vld_q, d_vld_d;
   logic        berr_q, berr_d;

   logic data_req;
   logic fetch_forced;

   assign data_req     = data_read | data_write;
   assign fetch_forced = in_mem_en && (fair_q == FAIR_MAX);

   // Next-state, grant and completion logic
   always_comb begin
      state_d     = state_q;
      fair_d      = fair_q;
      wait_d      = wait_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      in_mem_d    = in_mem_q;
      data_in_d   = data_in_q;
      in_vld_d    = 1'b0;
      d_vld_d     = 1'b0;
      berr_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!in_mem_en) fair_d = '0;
            if (data_req && !fetch_forced) begin
               state_d     = DATA;
               wait_d      = '0;
               mem_addr_d  = data_addr;
               mem_wdata_d = data_out;
               // A simultaneous read and write is treated as a write.
               mem_wr_d    = data_write;
               mem_rd_d    = !data_write;
               if (in_mem_en && (fair_q < FAIR_MAX)) fair_d = fair_q + 4'd1;
            end else if (in_mem_en) begin
               state_d    = FETCH;
               wait_d     = '0;
               mem_addr_d = in_mem_addr;
               mem_rd_d   = 1'b1;
               mem_wr_d   = 1'b0;
               fair_d     = '0;
            end
         end
         FETCH, DATA: begin
            if (mem_ready || (wait_q == WAIT_LAST)) begin
               state_d  = DONE;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               berr_d   = !mem_ready;
               if (state_q == FETCH) begin
                  in_vld_d = 1'b1;
                  if (mem_ready) in_mem_d = mem_rdata;
               end else begin
                  d_vld_d = 1'b1;
                  if (mem_ready && mem_rd_q) data_in_d = mem_rdata;
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         fair_q      <= '0;
         wait_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         in_mem_q    <= '0;
         data_in_q   <= '0;
         in_vld_q    <= 1'b0;
         d_vld_q     <= 1'b0;
         berr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fair_q      <= fair_d;
         wait_q      <= wait_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         in_mem_q    <= in_mem_d;
         data_in_q   <= data_in_d;
         in_vld_q    <= in_vld_d;
         d_vld_q     <= d_vld_d;
         berr_q      <= berr_d;
      end
   end

   assign in_mem       = in_mem_q;
   assign in_mem_valid = in_vld_q;
   assign data_in      = data_in_q;
   assign data_valid   = d_vld_q;
   assign bus_err      = berr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_rd       = mem_rd_q;
   assign mem_wr       = mem_wr_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Scoreboard bench for scc_mem_arbiter: stimulus pushes the expected
// completions, a monitor checks every strobe cycle and every valid pulse.
module tb_scc_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_mem_en = 1'b0;
   logic [31:0] in_mem_addr = '0;
   logic [31:0] in_mem;
   logic        in_mem_valid;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_out = '0;
   logic [31:0] data_in;
   logic        data_valid;
   logic        bus_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   scc_mem_arbiter #(.FAIRNESS(4), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .in_mem_en(in_mem_en), .in_mem_addr(in_mem_addr), .in_mem(in_mem),
      .in_mem_valid(in_mem_valid),
      .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
      .data_out(data_out), .data_in(data_in), .data_valid(data_valid),
      .bus_err(bus_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fetch;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;   // in_mem (fetch) or data_in (data) at the valid pulse
      bit          berr;
      int          strb;   // strobe cycles for this access
      int          lat;    // request-to-valid cycles, 0 = not checked
      int          t;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   ready_delay = 1;  // strobe cycle on which memory answers, 0 = never

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'hDEAD_BEEF;
         32'h200: return 32'hF00D_0200;
         32'h300: return 32'hDA7A_0300;
         default: return {16'hA5A5, a[15:0]};
      endcase
   endfunction

   task automatic push(input bit fetch, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] data,
                       input bit berr, input int strb, input int lat);
      exp_t e;
      e.fetch = fetch; e.wr = wr; e.addr = addr; e.wdata = wdata; e.data = data;
      e.berr = berr; e.strb = strb; e.lat = lat; e.t = cyc;
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for the requested valid pulse
   task automatic wait_valid(input bit want_fetch);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (want_fetch ? in_mem_valid : data_valid) return;
      end
      n_chk++;
      $display("FAIL wait_valid: no %s valid within 100 cycles", want_fetch ? "fetch" : "data");
   endtask

   // Wait (bounded) for n valid pulses of either kind
   task automatic wait_pulses(input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_mem_valid || data_valid) seen++;
         if (seen == n) return;
      end
      n_chk++;
      $display("FAIL wait_pulses: saw %0d of %0d valids", seen, n);
   endtask

   // Memory model: answers on the ready_delay-th strobe cycle
   initial begin
      int sc;
      sc = 0;
      forever begin
         @(negedge clk);
         if (reset && (mem_rd || mem_wr)) begin
            sc++;
            mem_ready = (ready_delay != 0) && (sc == ready_delay);
            mem_rdata = mem_ready ? mem_word(mem_addr) : 32'h0BAD_0BAD;
         end else begin
            sc = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // Monitor: checks strobes against the head entry and completions on valid
   initial begin
      int   sc;
      exp_t e;
      sc = 0;
      forever begin
         @(negedge clk);
         if (!reset) sc = 0;
         else begin
            if (mem_rd || mem_wr) begin
               sc++;
               if (exp_q.size() > 0) begin
                  e = exp_q[0];
                  chk("strobe", {mem_rd, mem_wr, mem_addr, e.wr ? mem_wdata : 32'h0},
                      {~e.wr, e.wr, e.addr, e.wr ? e.wdata : 32'h0});
               end
            end
            if (in_mem_valid || data_valid) begin
               if (exp_q.size() == 0) chk("unexpected_valid", {in_mem_valid, data_valid}, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("which_valid", {in_mem_valid, data_valid}, e.fetch ? 2'b10 : 2'b01);
                  chk("bus_err", bus_err, e.berr);
                  chk("done_addr", mem_addr, e.addr);
                  chk("rdata", e.fetch ? in_mem : data_in, e.data);
                  chk("strobe_cycles", sc, e.strb);
                  if (e.lat != 0) chk("latency", cyc - e.t, e.lat);
               end
               sc = 0;
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      repeat (3) @(negedge clk);
      chk("reset_regs", {in_mem, data_in, mem_addr, mem_wdata}, 0);
      chk("reset_ctl", {in_mem_valid, data_valid, bus_err, mem_rd, mem_wr}, 0);
      reset = 1'b1;
      @(negedge clk);

      // Fetch, memory answers on first strobe cycle
      ready_delay = 1;
      push(1, 0, 32'h100, 0, 32'hDEAD_BEEF, 0, 1, 2);
      in_mem_en = 1'b1; in_mem_addr = 32'h100;
      wait_valid(1);
      in_mem_en = 1'b0;
      repeat (2) @(negedge clk);

      // Simultaneous fetch and load: load first, then fetch, no duplicates
      push(0, 0, 32'h300, 0, 32'hDA7A_0300, 0, 1, 0);
      push(1, 0, 32'h200, 0, 32'hF00D_0200, 0, 1, 0);
      in_mem_en = 1'b1; in_mem_addr = 32'h200;
      data_read = 1'b1; data_addr = 32'h300;
      wait_valid(0);
      data_read = 1'b0;
      wait_valid(1);
      in_mem_en = 1'b0;
      repeat (3) @(negedge clk);

      // Fairness: fetch held with back-to-back loads -> DDDDF DDDDF
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(0, 0, 32'h300, 0, 32'hDA7A_0300, 0, 1, 0);
         push(1, 0, 32'h200, 0, 32'hF00D_0200, 0, 1, 0);
      end
      in_mem_en = 1'b1; data_read = 1'b1;
      wait_pulses(10);
      in_mem_en = 1'b0; data_read = 1'b0;
      repeat (3) @(negedge clk);

      // Store with read also high: write wins, data_in keeps last load
      ready_delay = 3;
      push(0, 1, 32'h40, 32'h1234_5678, 32'hDA7A_0300, 0, 3, 0);
      data_write = 1'b1; data_read = 1'b1; data_addr = 32'h40; data_out = 32'h1234_5678;
      wait_valid(0);
      data_write = 1'b0; data_read = 1'b0;
      repeat (2) @(negedge clk);

      // Timeout: memory never answers, 8 strobe cycles then valid + bus_err
      ready_delay = 0;
      push(0, 0, 32'h80, 0, 32'hDA7A_0300, 1, 8, 0);
      data_read = 1'b1; data_addr = 32'h80;
      wait_valid(0);
      data_read = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-access: outputs clear before the next edge, no valid pulse
      in_mem_en = 1'b1; in_mem_addr = 32'h180;
      repeat (3) @(negedge clk);
      chk("mid_access_rd", mem_rd, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_regs", {in_mem, data_in, mem_addr, mem_wdata}, 0);
      chk("async_rst_ctl", {in_mem_valid, data_valid, bus_err, mem_rd, mem_wr}, 0);
      in_mem_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Fetch after reset completes normally
      ready_delay = 2;
      push(1, 0, 32'h200, 0, 32'hF00D_0200, 0, 2, 3);
      in_mem_en = 1'b1; in_mem_addr = 32'h200;
      wait_valid(1);
      in_mem_en = 1'b0;
      repeat (4) @(negedge clk);

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
